bl_sub_integ: RTL

BL_SUB_INTEG -- requirements
Module: bl_sub_integ

---
 rtl/bl_sub_integ.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bl_sub_integ.sv
// Baseline-subtracting 4-channel event integrator with saturating accumulators.
// Optional build macro BL_CLAMP_EN: clamp negative per-sample differences to zero.
module bl_sub_integ #(
  parameter int ADC_BIT = 16,
  parameter int ACC_BIT = 32,
  parameter int MAX_LEN = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bl_valid,
  input  logic [4*ADC_BIT-1:0]   bl_data,
  input  logic                   in_valid,
  input  logic [4*ADC_BIT-1:0]   din,
  output logic                   out_valid,
  output logic [4*ACC_BIT-1:0]   sum_data,
  output logic [15:0]            sample_cnt,
  output logic [3:0]             ovf,
  output logic                   trunc,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, INTEG, FLUSH} state_t;

  localparam logic signed [ACC_BIT:0] SAT_POS = {2'b00, {(ACC_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT:0] SAT_NEG = -SAT_POS;

  state_t state, stateNext;

  logic [4*ADC_BIT-1:0]      blPend, blAct, baseSel;
  logic                      blOk;
  logic [3:0][ACC_BIT-1:0]   acc, accNext;
  logic [15:0]               cnt, cntNext;
  logic [3:0]                ovfRun, ovfHit, ovfNew;
  logic                      cntAtMax;
  logic                      load, accum, emit, emitTrunc;

  // At event start the baseline comes from the pending register, or straight
  // from bl_data when an update lands in the same cycle.
  assign baseSel  = (state == IDLE) ? (bl_valid ? bl_data : blPend) : blAct;
  assign cntNext  = (state == IDLE) ? 16'd1 : cnt + 16'd1;
  assign cntAtMax = (cntNext == 16'(MAX_LEN));
  assign ovfNew   = ((state == IDLE) ? 4'b0000 : ovfRun) | ovfHit;
  assign busy     = (state != IDLE);

  for (genvar ch = 0; ch < 4; ch++) begin : gCh
    logic [ADC_BIT-1:0]      smp, base;
    logic signed [ADC_BIT:0] diffRaw, diff;
    logic signed [ACC_BIT:0] sumW;

    assign smp     = din[ch*ADC_BIT +: ADC_BIT];
    assign base    = baseSel[ch*ADC_BIT +: ADC_BIT];
    assign diffRaw = $signed({1'b0, smp}) - $signed({1'b0, base});
`ifdef BL_CLAMP_EN
    assign diff    = diffRaw[ADC_BIT] ? '0 : diffRaw;
`else
    assign diff    = diffRaw;
`endif
    // One guard bit lets the saturation test see the unclamped sum.
    assign sumW = ((state == IDLE) ? '0 : {acc[ch][ACC_BIT-1], acc[ch]})
                + {{(ACC_BIT-ADC_BIT){diff[ADC_BIT]}}, diff};

    assign accNext[ch] = (sumW > SAT_POS) ? SAT_POS[ACC_BIT-1:0] :
                         (sumW < SAT_NEG) ? SAT_NEG[ACC_BIT-1:0] :
                                            sumW[ACC_BIT-1:0];
    assign ovfHit[ch]  = (sumW > SAT_POS) || (sumW < SAT_NEG);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    accum     = 1'b0;
    emit      = 1'b0;
    emitTrunc = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && (blOk || bl_valid)) begin
          load = 1'b1;
          if (cntAtMax) begin
            emit      = 1'b1;
            emitTrunc = 1'b1;
            stateNext = FLUSH;
          end else begin
            stateNext = INTEG;
          end
        end
      end
      INTEG: begin
        if (in_valid) begin
          accum = 1'b1;
          if (cntAtMax) begin
            emit      = 1'b1;
            emitTrunc = 1'b1;
            stateNext = FLUSH;
          end
        end else begin
          emit      = 1'b1;
          stateNext = IDLE;
        end
      end
      FLUSH: begin
        if (!in_valid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blPend     <= '0;
      blAct      <= '0;
      blOk       <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      ovfRun     <= '0;
      out_valid  <= 1'b0;
      sum_data   <= '0;
      sample_cnt <= '0;
      ovf        <= '0;
      trunc      <= 1'b0;
    end else begin
      out_valid <= emit;
      if (bl_valid) begin
        blPend <= bl_data;
        blOk   <= 1'b1;
      end
      if (load) blAct <= baseSel;
      if (load || accum) begin
        acc    <= accNext;
        cnt    <= cntNext;
        ovfRun <= ovfNew;
      end
      // A truncating emit publishes the sample captured on this same edge.
      if (emit) begin
        trunc <= emitTrunc;
        if (emitTrunc) begin
          sum_data   <= accNext;
          sample_cnt <= cntNext;
          ovf        <= ovfNew;
        end else begin
          sum_data   <= acc;
          sample_cnt <= cnt;
          ovf        <= ovfRun;
        end
      end
    end
  end

endmodule
